turn_signal_controller: RTL and testbench
=========================================

TURN_SIGNAL_CONTROLLER -- requirements
Module: turn_signal_controller

Interface
REQ-001 SHALL have parameter PERIOD_CYC, default 25_000_000: blink period in clk cycles, at least 2.
REQ-002 SHALL have parameter ON_CYC, default 12_500_000: lit cycles per period, 1..PERIOD_CYC-1.
REQ-003 SHALL have parameter N_SEG, default 1: lamp segments per side, 1..8.
REQ-004 SHALL have parameter COMFORT_BLINKS, default 3: blink count for a tap request, 1..15.
REQ-005 SHALL have these ports (one clock; reset is synchronous and active-high):
 clk  in  1  system clock
 rst  in  1  synchronous active-high reset
 sw_left  in  1  left indicator switch, level
 sw_right  in  1  right indicator switch, level
 sw_hazard  in  1  hazard switch, level
 ess_active  in  1  emergency stop signal, level
 tap_left  in  1  one-cycle comfort request, left
 tap_right  in  1  one-cycle comfort request, right
 led_left  out  N_SEG  left lamp segments, registered
 led_right  out  N_SEG  right lamp segments, registered
 busy  out  1  high in any state other than IDLE

Function
REQ-006 SHALL have states IDLE, LEFT, RIGHT, HAZARD, COMF_L and COMF_R, evaluated every cycle.
REQ-007 SHALL use this priority: ess_active or sw_hazard or (sw_left and sw_right) -> HAZARD; else sw_left -> LEFT; else sw_right -> RIGHT; else comfort state or tap; else IDLE.
REQ-008 SHALL enter COMF_L on tap_left (COMF_R on tap_right) only when no switch or ESS input is asserted; simultaneous tap_left and tap_right SHALL be ignored.
REQ-009 SHALL cancel COMF_L to IDLE on tap_right, and cancel COMF_R to IDLE on tap_left; a tap on the same side SHALL reload the blink count.
REQ-010 SHALL end a comfort state in IDLE after COMFORT_BLINKS complete periods.
REQ-011 SHALL return to IDLE, or to the remaining higher-priority state, in the cycle after a level input drops; a comfort state SHALL NOT resume.
REQ-012 SHALL hold phase counter cnt at 0 in IDLE, count 0..PERIOD_CYC-1 otherwise, and wrap to 0.
REQ-013 SHALL reset cnt to 0 on every state change, so each new pattern begins lit.
REQ-014 SHALL compute lamp-on as cnt < ON_CYC.
REQ-015 SHALL drive every segment of each active side from lamp-on: both sides in HAZARD, one side otherwise, no segments in IDLE.
REQ-016 SHALL register outputs, giving 1 cycle latency from cnt to the LEDs.
REQ-017 SHALL size the comfort counter at 4 bits and cnt at clog2(PERIOD_CYC) bits.

Reset
REQ-018 SHALL, while rst is high at a clk edge, set state IDLE, cnt 0, comfort count 0, led_left 0, led_right 0 and busy 0.
REQ-019 SHALL apply reset mid-pattern, with the first post-reset cycle evaluated from IDLE.

Configuration
REQ-020 SHALL, when TURN_SIGNAL_SWEEP_EN is defined, light segment k during a lit phase only when cnt >= k*(ON_CYC/N_SEG), with segments accumulating lit from 0 to N_SEG-1.
REQ-021 SHALL, when TURN_SIGNAL_SWEEP_EN is not defined, drive all segments of a side identically per REQ-015; with N_SEG=1 both builds SHALL behave identically.

Structure
REQ-022 SHALL place the state encoding localparams and the priority ordering in shared package turn_signal_pkg.
REQ-023 SHALL place cnt, lamp-on and the one-cycle period-wrap pulse in sub-module blink_timebase, which has a synchronous restart input.

Verification (PERIOD_CYC=10, ON_CYC=5, N_SEG=4, COMFORT_BLINKS=3)
REQ-024 SHALL test sw_left held for 30 cycles -> led_left 4'hF for cycles 1-5 and 0 for cycles 6-10, repeating; led_right stays 0.
REQ-025 SHALL test a tap_left pulse -> exactly 3 lit phases on the left, then IDLE with busy=0 at cycle 31.
REQ-026 SHALL test tap_left then tap_right 7 cycles later -> all LEDs 0 in the next cycle with state IDLE.
REQ-027 SHALL test sw_right during LEFT, then ess_active asserted -> HAZARD with both sides lit in the first cycle after restart.
REQ-028 SHALL test rst asserted at cycle 13 of LEFT -> outputs 0 in the next cycle; pattern restarts lit once rst drops.
REQ-029 SHALL test TURN_SIGNAL_SWEEP_EN with sw_right -> led_right 0001, 0011, 0111, 1111 on successive cycles 1-4 (ON_CYC/N_SEG=1, capped by ON_CYC).

Source files
------------

// File: rtl/turn_signal_pkg.sv
// -----------------------------------------------------------------------------
// turn_signal_pkg
// Shared definitions for the turn signal controller:
//   - state encoding (state_t and the ST_* localparams)
//   - width of the comfort blink counter
//   - level_state(): the fixed priority ordering of the level inputs
//   - is_comfort(): true for the two tap-started comfort states
// -----------------------------------------------------------------------------
package turn_signal_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LEFT   = 3'd1;
  localparam state_t ST_RIGHT  = 3'd2;
  localparam state_t ST_HAZARD = 3'd3;
  localparam state_t ST_COMF_L = 3'd4;
  localparam state_t ST_COMF_R = 3'd5;

  localparam int COMF_W = 4;

  // Highest-priority state requested by the level inputs alone. ST_IDLE
  // means no level input is asserted, so taps and comfort may take over.
  function automatic state_t level_state(input logic ess, input logic hazard,
                                         input logic left, input logic right);
    if (ess || hazard || (left && right)) return ST_HAZARD;
    else if (left)                        return ST_LEFT;
    else if (right)                       return ST_RIGHT;
    else                                  return ST_IDLE;
  endfunction

  function automatic logic is_comfort(input state_t s);
    return (s == ST_COMF_L) || (s == ST_COMF_R);
  endfunction

endpackage

// File: rtl/blink_timebase.sv
// -----------------------------------------------------------------------------
// blink_timebase
// Phase counter for the blink pattern. cnt runs 0..PERIOD_CYC-1 and wraps;
// restart forces it back to 0 on the next edge.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   restart  in   synchronous restart of the phase counter
//   cnt      out  CNT_W  current phase
//   lamp_on  out  1      lit part of the period (cnt < ON_CYC)
//   wrap     out  1      one-cycle pulse on the last cycle of a period
// -----------------------------------------------------------------------------
module blink_timebase #(
  parameter int PERIOD_CYC = 25_000_000,
  parameter int ON_CYC     = 12_500_000,
  parameter int CNT_W      = $clog2(PERIOD_CYC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  output logic [CNT_W-1:0] cnt,
  output logic             lamp_on,
  output logic             wrap
);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the edge, independent of block order.
    if (rst || restart)  cnt <= '0;
    else if (wrap)       cnt <= '0;
    else                 cnt <= cnt + CNT_W'(1);
  end

  assign wrap    = (cnt == CNT_W'(PERIOD_CYC - 1));
  assign lamp_on = (cnt < CNT_W'(ON_CYC));

endmodule

// File: rtl/turn_signal_controller.sv
// -----------------------------------------------------------------------------
// turn_signal_controller
// Left/right/hazard indicator with tap-started comfort blinking.
// Optional build macro: TURN_SIGNAL_SWEEP_EN -- during the lit phase the
// segments of a side light progressively (segment k once cnt >= k*step)
// instead of all together.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   sw_left     in   left indicator switch (level)
//   sw_right    in   right indicator switch (level)
//   sw_hazard   in   hazard switch (level)
//   ess_active  in   emergency stop signal (level)
//   tap_left    in   one-cycle comfort request, left
//   tap_right   in   one-cycle comfort request, right
//   led_left    out  N_SEG  left lamp segments (registered)
//   led_right   out  N_SEG  right lamp segments (registered)
//   busy        out  1      state is not IDLE
// -----------------------------------------------------------------------------
module turn_signal_controller
  import turn_signal_pkg::*;
#(
  parameter int PERIOD_CYC     = 25_000_000,
  parameter int ON_CYC         = 12_500_000,
  parameter int N_SEG          = 1,
  parameter int COMFORT_BLINKS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_left,
  input  logic             sw_right,
  input  logic             sw_hazard,
  input  logic             ess_active,
  input  logic             tap_left,
  input  logic             tap_right,
  output logic [N_SEG-1:0] led_left,
  output logic [N_SEG-1:0] led_right,
  output logic             busy
);

  localparam int CNT_W = $clog2(PERIOD_CYC);

  state_t             state, next_state;
  logic [COMF_W-1:0]  comf_cnt;
  logic               reload;
  logic               restart;
  logic [CNT_W-1:0]   cnt;
  logic               lamp_on;
  logic               wrap;
  logic               left_active, right_active;
  logic [N_SEG-1:0]   seg_mask;

  blink_timebase #(
    .PERIOD_CYC (PERIOD_CYC),
    .ON_CYC     (ON_CYC),
    .CNT_W      (CNT_W)
  ) u_timebase (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .cnt     (cnt),
    .lamp_on (lamp_on),
    .wrap    (wrap)
  );

  // Every state change, and every cycle spent in IDLE, pins the phase to 0
  // so a new pattern always begins with the lit phase.
  assign restart = (next_state != state) || (next_state == ST_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    next_state = ST_IDLE;
    reload     = 1'b0;
    if (level_state(ess_active, sw_hazard, sw_left, sw_right) != ST_IDLE) begin
      next_state = level_state(ess_active, sw_hazard, sw_left, sw_right);
    end else if (tap_left && !tap_right) begin
      // An opposite-side tap cancels comfort; same side (re)starts it.
      next_state = (state == ST_COMF_R) ? ST_IDLE : ST_COMF_L;
      reload     = (state != ST_COMF_R);
    end else if (tap_right && !tap_left) begin
      next_state = (state == ST_COMF_L) ? ST_IDLE : ST_COMF_R;
      reload     = (state != ST_COMF_L);
    end else if (is_comfort(state)) begin
      // Leave on the wrap that completes the last requested period.
      next_state = (wrap && comf_cnt == COMF_W'(1)) ? ST_IDLE : state;
    end
  end

  // Remaining comfort periods; a reload wins over a coincident wrap.
  always_ff @(posedge clk) begin
    if (rst)                          comf_cnt <= '0;
    else if (reload)                  comf_cnt <= COMF_W'(COMFORT_BLINKS);
    else if (!is_comfort(next_state)) comf_cnt <= '0;
    else if (wrap)                    comf_cnt <= comf_cnt - COMF_W'(1);
  end

  // Output decode
  always_comb begin
    busy         = (state != ST_IDLE);
    left_active  = (state == ST_LEFT)  || (state == ST_HAZARD) || (state == ST_COMF_L);
    right_active = (state == ST_RIGHT) || (state == ST_HAZARD) || (state == ST_COMF_R);
  end

`ifdef TURN_SIGNAL_SWEEP_EN
  localparam int SEG_STEP = ON_CYC / N_SEG;

  always_comb begin
    seg_mask = '0;
    for (int k = 0; k < N_SEG; k++) begin
      seg_mask[k] = lamp_on && (int'(cnt) >= k * SEG_STEP);
    end
  end
`else
  assign seg_mask = {N_SEG{lamp_on}};
`endif

  // Registered lamp drive: one cycle behind cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_left  <= '0;
      led_right <= '0;
    end else begin
      led_left  <= left_active  ? seg_mask : '0;
      led_right <= right_active ? seg_mask : '0;
    end
  end

endmodule

// File: tb/tb_turn_signal_controller.sv
// -----------------------------------------------------------------------------
// tb_turn_signal_controller
// Self-checking bench for turn_signal_controller with PERIOD_CYC=10,
// ON_CYC=5, N_SEG=4, COMFORT_BLINKS=3. A mode/age reference model predicts
// the lamps and busy each cycle; directed scenarios add literal expectations.
// Honours TURN_SIGNAL_SWEEP_EN in the model and in the sweep scenario.
// -----------------------------------------------------------------------------
module tb_turn_signal_controller;

  localparam int P  = 10;
  localparam int ON = 5;
  localparam int NS = 4;
  localparam int CB = 3;

  // Bench-side mode names
  localparam int M_IDLE = 0, M_L = 1, M_R = 2, M_H = 3, M_CL = 4, M_CR = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_left = 1'b0, sw_right = 1'b0, sw_hazard = 1'b0, ess_active = 1'b0;
  logic tap_left = 1'b0, tap_right = 1'b0;
  logic [NS-1:0] led_left, led_right;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  turn_signal_controller #(
    .PERIOD_CYC     (P),
    .ON_CYC         (ON),
    .N_SEG          (NS),
    .COMFORT_BLINKS (CB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_left    (sw_left),
    .sw_right   (sw_right),
    .sw_hazard  (sw_hazard),
    .ess_active (ess_active),
    .tap_left   (tap_left),
    .tap_right  (tap_right),
    .led_left   (led_left),
    .led_right  (led_right),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lamp image for a phase within the period.
  function automatic logic [NS-1:0] pat(input int ph);
    logic [NS-1:0] r;
    r = '0;
    if (ph < ON) begin
`ifdef TURN_SIGNAL_SWEEP_EN
      for (int k = 0; k < NS; k++) if (ph >= k * (ON / NS)) r[k] = 1'b1;
`else
      r = '1;
`endif
    end
    return r;
  endfunction

  // ---------------- reference model ----------------
  // mode: what the indicator is doing; age: cycles since the mode began;
  // end_age: age at which a comfort mode finishes its last period.
  int m = M_IDLE, age = 0, end_age = 0;
  logic [NS-1:0] exp_l = '0, exp_r = '0;
  logic exp_busy = 1'b0;

  always @(posedge clk) begin
    int nm, na, ne, d;
    if (rst) begin
      m <= M_IDLE; age <= 0; end_age <= 0;
      exp_l <= '0; exp_r <= '0; exp_busy <= 1'b0;
    end else begin
      exp_l <= (m == M_L || m == M_H || m == M_CL) ? pat(age % P) : '0;
      exp_r <= (m == M_R || m == M_H || m == M_CR) ? pat(age % P) : '0;
      if (ess_active || sw_hazard || (sw_left && sw_right)) nm = M_H;
      else if (sw_left)                nm = M_L;
      else if (sw_right)               nm = M_R;
      else if (tap_left && !tap_right) nm = (m == M_CR) ? M_IDLE : M_CL;
      else if (tap_right && !tap_left) nm = (m == M_CL) ? M_IDLE : M_CR;
      else if (m == M_CL || m == M_CR) nm = (age == end_age) ? M_IDLE : m;
      else                             nm = M_IDLE;
      ne = end_age;
      if (nm != m) begin
        na = 0;
        if (nm == M_CL || nm == M_CR) ne = CB * P - 1;
      end else if ((nm == M_CL && tap_left && !tap_right) ||
                   (nm == M_CR && tap_right && !tap_left)) begin
        // Count CB wraps strictly after this tap cycle.
        d = P - 1 - (age % P);
        if (d == 0) d = P;
        ne = age + d + (CB - 1) * P;
        na = age + 1;
      end else begin
        na = (nm == M_IDLE) ? 0 : age + 1;
      end
      m <= nm; age <= na; end_age <= ne;
      exp_busy <= (nm != M_IDLE);
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_led_left",  32'(led_left),  32'(exp_l));
      check("cyc_led_right", 32'(led_right), 32'(exp_r));
      check("cyc_busy",      32'(busy),      32'(exp_busy));
    end
  end

  // Literal expectation checked against both the DUT and the model.
  task automatic lit(input string name, input logic [31:0] dut_v,
                     input logic [31:0] mdl_v, input logic [31:0] want);
    check(name, dut_v, want);
    check({name, "_model"}, mdl_v, want);
  endtask

  task automatic clear_inputs();
    sw_left = 0; sw_right = 0; sw_hazard = 0; ess_active = 0;
    tap_left = 0; tap_right = 0;
  endtask

  // Two reset cycles; returns at a falling edge with rst just released.
  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int lit_cycles, phases;
    logic prev_lit;
    logic [NS-1:0] sweep_exp [1:4];

    do_reset();
    chk_en = 1'b1;
    lit("reset_led_left",  32'(led_left),  32'(exp_l), 32'h0);
    lit("reset_led_right", 32'(led_right), 32'(exp_r), 32'h0);
    lit("reset_busy",      32'(busy),      32'(exp_busy), 32'h0);

    // Left switch held for 30 cycles
    sw_left = 1;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1 || c == 5 || c == 11 || c == 25)
        lit("left_lit", 32'(led_left), 32'(exp_l), 32'hF);
      if (c == 6 || c == 10 || c == 16)
        lit("left_dark", 32'(led_left), 32'(exp_l), 32'h0);
      if (c == 3) lit("left_right_off", 32'(led_right), 32'(exp_r), 32'h0);
    end

    // Comfort tap: three lit phases, then idle
    do_reset();
    tap_left = 1;
    lit_cycles = 0; phases = 0; prev_lit = 0;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c == 0) tap_left = 0;
      if (led_left == 4'hF) begin
        lit_cycles++;
        if (!prev_lit) phases++;
      end
      prev_lit = (led_left == 4'hF);
      if (c == 29) lit("comf_busy_last", 32'(busy), 32'(exp_busy), 32'h1);
      if (c == 30) lit("comf_busy_end",  32'(busy), 32'(exp_busy), 32'h0);
    end
    check("comf_phases", 32'(phases), 32'd3);
    check("comf_lit_cycles", 32'(lit_cycles), 32'd15);

    // Comfort cancelled by an opposite tap 7 cycles later
    do_reset();
    tap_left = 1;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (c == 0) tap_left = 0;
      if (c == 6) begin
        lit("cancel_busy_before", 32'(busy), 32'(exp_busy), 32'h1);
        tap_right = 1;
      end
      if (c == 7) begin
        tap_right = 0;
        lit("cancel_busy", 32'(busy), 32'(exp_busy), 32'h0);
        lit("cancel_left", 32'(led_left), 32'(exp_l), 32'h0);
        lit("cancel_right", 32'(led_right), 32'(exp_r), 32'h0);
      end
      if (c == 8) lit("cancel_left_after", 32'(led_left), 32'(exp_l), 32'h0);
    end

    // Left, then right added (hazard), then ESS takes over
    do_reset();
    sw_left = 1;
    for (int c = 0; c <= 23; c++) begin
      @(negedge clk);
      if (c == 6) sw_right = 1;
      if (c == 8) begin
        lit("haz_left_first",  32'(led_left),  32'(exp_l), 32'hF);
        lit("haz_right_first", 32'(led_right), 32'(exp_r), 32'hF);
      end
      if (c == 10) begin ess_active = 1; sw_left = 0; sw_right = 0; end
      if (c == 15) lit("haz_ess_dark", 32'(led_right), 32'(exp_r), 32'h0);
      if (c == 18) begin
        lit("haz_ess_left",  32'(led_left),  32'(exp_l), 32'hF);
        lit("haz_ess_right", 32'(led_right), 32'(exp_r), 32'hF);
      end
      if (c == 20) ess_active = 0;
      if (c == 21) lit("haz_release_busy", 32'(busy), 32'(exp_busy), 32'h0);
    end

    // Reset in the middle of LEFT
    do_reset();
    sw_left = 1;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      if (c == 12) begin
        lit("rst_before", 32'(led_left), 32'(exp_l), 32'hF);
        rst = 1;
      end
      if (c == 13) begin
        lit("rst_led_left", 32'(led_left), 32'(exp_l), 32'h0);
        lit("rst_busy",     32'(busy),     32'(exp_busy), 32'h0);
        rst = 0;
      end
      if (c == 15) lit("rst_restart_lit", 32'(led_left), 32'(exp_l), 32'hF);
    end

    // Right switch: sweep or uniform segments
`ifdef TURN_SIGNAL_SWEEP_EN
    sweep_exp[1] = 4'b0001; sweep_exp[2] = 4'b0011;
    sweep_exp[3] = 4'b0111; sweep_exp[4] = 4'b1111;
`else
    sweep_exp[1] = 4'hF; sweep_exp[2] = 4'hF;
    sweep_exp[3] = 4'hF; sweep_exp[4] = 4'hF;
`endif
    do_reset();
    sw_right = 1;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4)
        lit("sweep_right", 32'(led_right), 32'(exp_r), 32'(sweep_exp[c]));
      if (c == 5) lit("sweep_full", 32'(led_right), 32'(exp_r), 32'hF);
      if (c == 6) lit("sweep_dark", 32'(led_right), 32'(exp_r), 32'h0);
    end

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      tap_left  = 0;
      tap_right = 0;
      rst = ($urandom_range(0, 399) == 0);
      if (sw_left)    sw_left    = ($urandom_range(0, 7) != 0);
      else            sw_left    = ($urandom_range(0, 29) == 0);
      if (sw_right)   sw_right   = ($urandom_range(0, 7) != 0);
      else            sw_right   = ($urandom_range(0, 29) == 0);
      if (sw_hazard)  sw_hazard  = ($urandom_range(0, 5) != 0);
      else            sw_hazard  = ($urandom_range(0, 79) == 0);
      if (ess_active) ess_active = ($urandom_range(0, 5) != 0);
      else            ess_active = ($urandom_range(0, 119) == 0);
      if (i < 2000) begin
        tap_left  = ($urandom_range(0, 11) == 0);
        tap_right = ($urandom_range(0, 11) == 0);
      end else begin
        tap_left  = ($urandom_range(0, 59) == 0);
        tap_right = ($urandom_range(0, 59) == 0);
      end
    end
    @(negedge clk);
    clear_inputs();
    rst = 0;
    repeat (40) @(negedge clk);
    check("final_idle_busy", 32'(busy), 32'h0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
